// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared types and default sizing for the simple-dual-port data RAM.
//   state_e      clear sequencer states (ST_CLEAR walks the array, ST_READY serves requests)
//   DW_DEF       default data width
//   AW_DEF       default address width (depth = 2**AW)
//   OUT_REG_DEF  default read pipeline depth selector (0: 1-cycle, 1: 2-cycle)
package data_ram_pkg;

  localparam int unsigned DW_DEF      = 8;
  localparam int unsigned AW_DEF      = 8;
  localparam int unsigned OUT_REG_DEF = 0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/data_ram_sdp_if.sv
// data_ram_sdp_if: request/response bundle between the processor and the data RAM.
//   cs, wr, waddr, data_in   write side (plus chip select), driven by the master
//   rd, raddr                read request, driven by the master
//   clr                      single-cycle full-clear request, driven by the master
//   data_out, rd_valid       read result and its one-cycle strobe, driven by the RAM
//   busy                     high while the RAM is clearing, driven by the RAM
interface data_ram_sdp_if
  import data_ram_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
);

  logic          cs;
  logic          wr;
  logic [AW-1:0] waddr;
  logic [DW-1:0] data_in;
  logic          rd;
  logic [AW-1:0] raddr;
  logic          clr;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          busy;

  modport master (
    output cs, wr, waddr, data_in, rd, raddr, clr,
    input  data_out, rd_valid, busy
  );

  modport slave (
    input  cs, wr, waddr, data_in, rd, raddr, clr,
    output data_out, rd_valid, busy
  );

endinterface

// File: rtl/data_ram_clr.sv
// data_ram_clr: clear sequencer for the data RAM.
// After reset, or on cs & clr while ready, it writes zero to every address in turn
// (one per cycle, address 0 upwards) and then returns to ST_READY.
//   clk          clock, rising edge
//   rst          synchronous active-high reset; restarts the sweep at address 0
//   i_cs         chip select; qualifies i_clr
//   i_clr        clear request pulse; ignored while a sweep is running
//   o_busy       high for the whole sweep
//   o_clr_we     write enable for the sweep (same as o_busy)
//   o_clr_addr   address being zeroed this cycle
module data_ram_clr
  import data_ram_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cs,
  input  logic          i_clr,
  output logic          o_busy,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_addr
);

  localparam logic [AW-1:0] LastAddr = {AW{1'b1}};

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_busy      = 1'b0;
    o_clr_we    = 1'b0;
    unique case (r_state)
      ST_CLEAR: begin
        o_busy    = 1'b1;
        o_clr_we  = 1'b1;
        // cnt wraps to 0 on the last address, ready for the next sweep.
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LastAddr) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (i_cs && i_clr) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/data_ram_sdp.sv
// data_ram_sdp: simple-dual-port data memory with one write port, one read port,
// write-first bypass, selectable read latency and a hardware clear sweep.
//   clk       clock, rising edge
//   rst       synchronous active-high reset; flushes reads and starts a clear sweep
//   bus       data_ram_sdp_if slave modport:
//               cs/wr/waddr/data_in  write request
//               rd/raddr             read request
//               clr                  clear request (wins over wr/rd in the same cycle)
//               data_out/rd_valid    read result, valid 1 (OUT_REG=0) or 2 (OUT_REG=1)
//                                    edges after the request is sampled
//               busy                 high during a clear sweep; requests are dropped
module data_ram_sdp
  import data_ram_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned OUT_REG = OUT_REG_DEF
) (
  input  logic           clk,
  input  logic           rst,
  data_ram_sdp_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];

  logic          w_busy;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;

  logic          w_req_ok;
  logic          w_wr_fire;
  logic          w_rd_fire;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rd_word;

  logic [DW-1:0] r_rd_data;
  logic          r_rd_vld;

  data_ram_clr #(
    .AW (AW)
  ) u_clr (
    .clk        (clk),
    .rst        (rst),
    .i_cs       (bus.cs),
    .i_clr      (bus.clr),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // A request only counts when ready, selected, and not overridden by clr.
  assign w_req_ok  = ~w_busy & bus.cs & ~bus.clr;
  assign w_wr_fire = w_req_ok & bus.wr;
  assign w_rd_fire = w_req_ok & bus.rd;

  // The sweep owns the write port while busy; user writes are already blocked then.
  assign w_we    = w_clr_we | w_wr_fire;
  assign w_waddr = w_clr_we ? w_clr_addr : bus.waddr;
  assign w_wdata = w_clr_we ? '0 : bus.data_in;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Write-first: a same-cycle write to the read address is forwarded.
  assign w_rd_word = (w_wr_fire && (bus.waddr == bus.raddr)) ? bus.data_in
                                                             : r_mem[bus.raddr];

  // First read stage; data holds between reads so data_out never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] r_out_data;
    logic          r_out_vld;

    // Not gated by busy: a read accepted before clr still completes.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_out_data <= '0;
        r_out_vld  <= 1'b0;
      end else begin
        r_out_vld <= r_rd_vld;
        if (r_rd_vld) begin
          r_out_data <= r_rd_data;
        end
      end
    end

    assign bus.data_out = r_out_data;
    assign bus.rd_valid = r_out_vld;
  end else begin : g_no_out_reg
    assign bus.data_out = r_rd_data;
    assign bus.rd_valid = r_rd_vld;
  end

  assign bus.busy = w_busy;

endmodule
